// File: rtl/ram_hs_pkg.sv
// ram_hs_pkg: state encoding and counter sizing shared by the RAM handshake master.
package ram_hs_pkg;

    typedef enum logic [3:0] {
        IDLE, R_SETUP, R_REQ, R_DATA, R_REL, R_DONE,
        W_SETUP, W_PULSE, W_HOLD, ABORT, RESP
    } state_e;

    localparam int ABORT_CYCLES = 2;

    // One counter serves timeouts, the write strobe and the abort pulse.
    function automatic int cnt_width(input int timeout, input int pulse);
        return $clog2((timeout > pulse ? timeout : pulse) + 1);
    endfunction

endpackage

// File: rtl/hs_sync.sv
// hs_sync: multi-flop synchronizer for a single RAM-originated handshake line.
module hs_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ram_hs_master.sv
// ram_hs_master: synchronous initiator for the RAM's four-phase read handshake and write strobe,
// with per-wait-state timeout that recovers a hung RAM through its reset input.
module ram_hs_master
    import ram_hs_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int WRITE_PULSE = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  ram_write,
    output logic                  ram_reset,
    output logic [ADDR_WIDTH-1:0] ram_write_address,
    output logic [ADDR_WIDTH-1:0] ram_read_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  ram_req_prev,
    input  logic                  ram_ack_prev,
    input  logic                  ram_req_next,
    output logic                  ram_ack_next
);

    localparam int CW = cnt_width(TIMEOUT, WRITE_PULSE);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  rst_ext_q;
    logic                  ack_prev_s, req_next_s;
    logic                  accept, timed_out;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_error_q, rsp_error_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  ram_write_q, ram_write_d;
    logic                  ram_reset_q, ram_reset_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  req_prev_q, req_prev_d;
    logic                  ack_next_q, ack_next_d;

    hs_sync #(.STAGES(SYNC_STAGES)) u_sync_ack (
        .clk(clk), .reset_n(reset_n), .d_i(ram_ack_prev), .q_o(ack_prev_s)
    );

    hs_sync #(.STAGES(SYNC_STAGES)) u_sync_next (
        .clk(clk), .reset_n(reset_n), .d_i(ram_req_next), .q_o(req_next_s)
    );

    assign accept    = (state_q == IDLE) && cmd_valid;
    assign timed_out = cnt_q == CW'(TIMEOUT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = cmd_write ? W_SETUP : R_SETUP;
            R_SETUP: state_d = R_REQ;
            R_REQ:   state_d = ack_prev_s  ? R_DATA : timed_out ? ABORT : R_REQ;
            R_DATA:  state_d = req_next_s  ? R_REL  : timed_out ? ABORT : R_DATA;
            R_REL:   state_d = !req_next_s ? R_DONE : timed_out ? ABORT : R_REL;
            R_DONE:  state_d = !ack_prev_s ? RESP   : timed_out ? ABORT : R_DONE;
            W_SETUP: state_d = W_PULSE;
            W_PULSE: if (cnt_q == CW'(WRITE_PULSE - 1)) state_d = W_HOLD;
            W_HOLD:  state_d = RESP;
            ABORT:   if (cnt_q == CW'(ABORT_CYCLES - 1)) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with state_q.
        cnt_d       = (state_d != state_q) ? '0 : cnt_q + CW'(state_q != IDLE);
        cmd_ready_d = state_d == IDLE;
        req_prev_d  = state_d inside {R_REQ, R_DATA, R_REL};
        ack_next_d  = state_d inside {R_REL, R_DONE};
        ram_write_d = state_d == W_PULSE;
        ram_reset_d = (state_d == ABORT) || rst_ext_q;
        rsp_valid_d = state_d == RESP;
        rsp_error_d = (state_d == RESP) && (state_q == ABORT);
        rsp_rdata_d = (state_q == R_DATA && req_next_s) ? ram_data_out : rsp_rdata_q;
        waddr_d     = accept ? cmd_addr  : waddr_q;
        raddr_d     = accept ? cmd_addr  : raddr_q;
        wdata_d     = accept ? cmd_wdata : wdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rst_ext_q   <= 1'b1;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            ram_write_q <= 1'b0;
            ram_reset_q <= 1'b1;
            waddr_q     <= '0;
            raddr_q     <= '0;
            wdata_q     <= '0;
            req_prev_q  <= 1'b0;
            ack_next_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_ext_q   <= 1'b0;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
            ram_write_q <= ram_write_d;
            ram_reset_q <= ram_reset_d;
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
            wdata_q     <= wdata_d;
            req_prev_q  <= req_prev_d;
            ack_next_q  <= ack_next_d;
        end
    end

    assign cmd_ready         = cmd_ready_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_error         = rsp_error_q;
    assign rsp_rdata         = rsp_rdata_q;
    assign ram_write         = ram_write_q;
    assign ram_reset         = ram_reset_q;
    assign ram_write_address = waddr_q;
    assign ram_read_address  = raddr_q;
    assign ram_data_in       = wdata_q;
    assign ram_req_prev      = req_prev_q;
    assign ram_ack_next      = ack_next_q;

endmodule

// File: tb/tb_ram_hs_master.sv
// tb_ram_hs_master: scoreboard bench with a behavioural handshake RAM for ram_hs_master.
module tb_ram_hs_master;

    localparam int TO = 64;
    localparam int WP = 2;

    typedef struct packed {
        logic       err;
        logic       rd;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [7:0] cmd_addr = '0, cmd_wdata = '0;
    logic       cmd_ready, rsp_valid, rsp_error;
    logic [7:0] rsp_rdata;
    logic       ram_write, ram_reset, ram_req_prev, ram_ack_next;
    logic [7:0] ram_write_address, ram_read_address, ram_data_in;
    logic [7:0] ram_data_out = '0;
    logic       ram_ack_prev = 1'b0, ram_req_next = 1'b0;

    always #5 clk = ~clk;

    ram_hs_master #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8), .SYNC_STAGES(2), .WRITE_PULSE(WP), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .ram_write(ram_write), .ram_reset(ram_reset),
        .ram_write_address(ram_write_address), .ram_read_address(ram_read_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .ram_req_prev(ram_req_prev), .ram_ack_prev(ram_ack_prev),
        .ram_req_next(ram_req_next), .ram_ack_next(ram_ack_next)
    );

    int         n_cmp = 0, n_bad = 0;
    exp_t       sb[$];
    logic [7:0] mem[256];
    logic [7:0] exp_mem[256];
    logic [7:0] last_rd = '0;
    int         cyc = 0, t_acc = 0, t_rsp = 0, rsp_cnt = 0;
    int         ack_dly = 3, data_dly = 3;
    logic       never_ack = 1'b0, early = 1'b0;
    int         m_st = 0, m_cnt = 0;
    int         overlap = 0, stab_bad = 0, wr_run = 0, last_pulse = 0, n_writes = 0;
    int         rr_run = 0, last_rr = 0;
    int         t_rq1 = 0, t_rq0 = 0, t_an1 = 0, t_an0 = 0, t_ak1 = 0;
    logic       prev_w = 1'b0, p_rq = 1'b0, p_an = 1'b0;
    logic [7:0] p_addr = '0, p_data = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // RAM model, response scoreboard and strobe/handshake monitors, all on the falling edge.
    task automatic watch();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (ram_reset) begin
                m_st = 0; m_cnt = 0; ram_ack_prev = 1'b0; ram_req_next = 1'b0;
            end else begin
                case (m_st)
                    0: if (ram_req_prev) begin
                        if (m_cnt >= ack_dly && !never_ack) begin
                            ram_ack_prev = 1'b1; t_ak1 = cyc; m_cnt = 0;
                            if (early) begin
                                ram_data_out = mem[ram_read_address]; ram_req_next = 1'b1; m_st = 2;
                            end else m_st = 1;
                        end else m_cnt++;
                    end
                    1: if (m_cnt >= data_dly) begin
                        ram_data_out = mem[ram_read_address]; ram_req_next = 1'b1; m_st = 2;
                    end else m_cnt++;
                    2: if (ram_ack_next) begin ram_req_next = 1'b0; m_st = 3; end
                    3: if (!ram_req_prev) begin ram_ack_prev = 1'b0; m_st = 0; m_cnt = 0; end
                    default: m_st = 0;
                endcase
            end
            if (ram_write && !prev_w) mem[ram_write_address] = ram_data_in;
            if (reset_n) begin
                if (ram_write && ram_req_prev) overlap++;
                if ((ram_write || prev_w) && (ram_write_address !== p_addr || ram_data_in !== p_data))
                    stab_bad++;
                if (ram_write) wr_run++;
                else if (prev_w) begin last_pulse = wr_run; wr_run = 0; n_writes++; end
                if (ram_reset) rr_run++;
                else if (rr_run != 0) begin last_rr = rr_run; rr_run = 0; end
                if (ram_req_prev && !p_rq) t_rq1 = cyc;
                if (!ram_req_prev && p_rq) t_rq0 = cyc;
                if (ram_ack_next && !p_an) t_an1 = cyc;
                if (!ram_ack_next && p_an) t_an0 = cyc;
                if (rsp_valid) begin
                    rsp_cnt++; t_rsp = cyc;
                    if (sb.size() == 0) check("rsp_unexpected", 1, 0);
                    else begin
                        e = sb.pop_front();
                        check("rsp_error", rsp_error, e.err);
                        if (e.rd) check("rsp_rdata", rsp_rdata, e.data);
                    end
                end
            end
            prev_w = ram_write; p_rq = ram_req_prev; p_an = ram_ack_next;
            p_addr = ram_write_address; p_data = ram_data_in;
        end
    endtask

    task automatic push_exp(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic err);
        exp_t e;
        e.err  = err;
        e.rd   = !wr;
        e.data = wr ? 8'h00 : (err ? last_rd : exp_mem[a]);
        if (wr) exp_mem[a] = d;
        else if (!err) last_rd = exp_mem[a];
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) check("ready_timeout", cmd_ready, 1);
    endtask

    task automatic send(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic err);
        wait_ready();
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        push_exp(wr, a, d, err);
        @(posedge clk);
        t_acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
        check("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0, nw0, n, lat;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i) ^ 8'h3C;
            exp_mem[i] = 8'(i) ^ 8'h3C;
        end
        mem[8'h10] = 8'h5A;
        exp_mem[8'h10] = 8'h5A;
        fork watch(); join_none

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_ram_reset", ram_reset, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_req_prev", ram_req_prev, 0);
        check("rst_ack_next", ram_ack_next, 0);
        check("rst_write", ram_write, 0);
        check("rst_waddr", ram_write_address, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ext_hold", ram_reset, 1);
        @(negedge clk);
        check("rst_ext_drop", ram_reset, 0);

        // Basic read with 3-cycle ack/data delays
        send(1'b0, 8'h10, 8'h00, 1'b0);
        drain();
        check("hs_order", (t_rq1 < t_ak1) && (t_ak1 < t_an1) && (t_an1 < t_rq0) && (t_rq0 < t_an0), 1);
        check("idle_lines", {ram_req_prev, ram_ack_next, ram_ack_prev, ram_req_next}, 0);
        check("read_rsp_cnt", rsp_cnt, 1);

        // Write at top address, then read back
        nw0 = n_writes;
        send(1'b1, 8'hFF, 8'hA5, 1'b0);
        drain();
        check("wr_pulse_len", last_pulse, WP);
        check("wr_count", n_writes - nw0, 1);
        check("wr_stable", stab_bad, 0);
        send(1'b0, 8'hFF, 8'h00, 1'b0);
        drain();

        // RAM never acknowledges: timeout, abort pulse, then recovery
        never_ack = 1'b1;
        send(1'b0, 8'h20, 8'h00, 1'b1);
        drain();
        lat = t_rsp - t_acc;
        check("to_latency", (lat >= TO) && (lat <= TO + 12), 1);
        check("abort_pulse", last_rr, 2);
        check("to_lines", {ram_req_prev, ram_ack_next}, 0);
        never_ack = 1'b0;
        send(1'b0, 8'h20, 8'h00, 1'b0);
        drain();

        // Data-ready already high together with ack
        early = 1'b1;
        send(1'b0, 8'h10, 8'h00, 1'b0);
        drain();
        early = 1'b0;

        // Command held valid while a read is in flight
        rc0 = rsp_cnt;
        nw0 = n_writes;
        send(1'b0, 8'h10, 8'h00, 1'b0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h33; cmd_wdata = 8'h77;
        @(negedge clk);
        check("busy_not_ready", cmd_ready, 0);
        wait_ready();
        check("busy_after_rsp", rsp_cnt - rc0, 1);
        push_exp(1'b1, 8'h33, 8'h77, 1'b0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        drain();
        check("busy_once", n_writes - nw0, 1);
        send(1'b0, 8'h33, 8'h00, 1'b0);
        drain();

        // Reset asserted in the middle of a read's data wait
        data_dly = 30;
        send(1'b0, 8'h10, 8'h00, 1'b0);
        n = 0;
        while (!ram_ack_prev && n < 50) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        check("busy_before_rst", ram_req_prev, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_req_prev", ram_req_prev, 0);
        check("mid_rst_ack_next", ram_ack_next, 0);
        check("mid_rst_ram_reset", ram_reset, 1);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_rdata", rsp_rdata, 0);
        sb.delete();
        last_rd = '0;
        data_dly = 3;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        send(1'b0, 8'h10, 8'h00, 1'b0);
        drain();

        // Back-to-back alternating write/read at the address extremes
        rc0 = rsp_cnt;
        for (int i = 0; i < 100; i++) begin
            ack_dly  = $urandom_range(0, 4);
            data_dly = $urandom_range(0, 4);
            send(i % 2 == 0, ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00, 8'($urandom), 1'b0);
        end
        drain();
        check("rand_rsp_cnt", rsp_cnt - rc0, 100);
        check("no_overlap", overlap, 0);
        check("wr_stable_all", stab_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_hs_master.md
Name: ram_hs_master

Overview:
- Synchronous initiator for the memory block's asynchronous req/ack interface; sits between the MC14500B core and the RAM.
- Accepts one read or write command at a time over a valid/ready port.
- Reads: sequences the four-phase req_prev/ack_prev and req_next/ack_next handshakes. Writes: generates a clean write strobe with address/data setup and hold.
- Returns read data or error on a one-cycle response port; a timeout counter recovers a hung RAM via its reset input.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 8, RAM address width.
- SYNC_STAGES, 2, flops per synchronizer on RAM-originated handshake inputs (min 2).
- WRITE_PULSE, 2, cycles the write strobe stays high (min 1).
- TIMEOUT, 64, cycles allowed per wait state before abort (min 4).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle, command accepted when valid&ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  word address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data, held until next read response
- rsp_error  out  1  qualified by rsp_valid: handshake timed out
- ram_write  out  1  RAM write strobe (RAM samples on rising edge)
- ram_reset  out  1  RAM handshake reset
- ram_write_address  out  ADDR_WIDTH  registered
- ram_read_address  out  ADDR_WIDTH  registered
- ram_data_in  out  DATA_WIDTH  registered write data
- ram_data_out  in  DATA_WIDTH  RAM read data
- ram_req_prev  out  1  read request to RAM
- ram_ack_prev  in  1  RAM acknowledge (async, synchronized)
- ram_req_next  in  1  RAM data-ready (async, synchronized)
- ram_ack_next  out  1  acknowledge of data-ready

Behaviour:
- Reset state:
  - State IDLE. cmd_ready=1.
  - ram_reset=1 while reset_n low, then held 1 for one further clk.
  - All other outputs 0; rsp_rdata=0.
- All outputs are registered. ram_ack_prev and ram_req_next pass through SYNC_STAGES flops before use. ram_data_out is sampled only after synchronized ram_req_next=1.
- IDLE:
  - cmd_ready=1.
  - On valid&ready: latch addr/wdata into the RAM address/data outputs, drop cmd_ready, go to R_SETUP or W_SETUP.
  - Both address outputs are loaded from cmd_addr; only the one relevant to the command is meaningful.
- Read path:
  - R_SETUP: one cycle, address stable.
  - R_REQ: ram_req_prev=1; wait sync ack_prev=1.
  - R_DATA: wait sync req_next=1, then capture ram_data_out into rsp_rdata and set ram_ack_next=1.
  - R_REL: wait sync req_next=0, then ram_req_prev=0.
  - R_DONE: wait sync ack_prev=0, then ram_ack_next=0, go to RESP.
- Write path:
  - W_SETUP: one cycle, address/data stable.
  - W_PULSE: ram_write=1 for exactly WRITE_PULSE cycles.
  - W_HOLD: ram_write=0 for one cycle, address/data held.
  - Then RESP.
- RESP: rsp_valid=1 for one cycle, rsp_error=0, go to IDLE with cmd_ready=1 the same edge. Minimum command-to-next-accept gap = state count + sync latency.
- Timeout:
  - Counter of width clog2(TIMEOUT+1) is cleared on every state entry and increments in wait states (R_REQ, R_DATA, R_REL, R_DONE).
  - On reaching TIMEOUT: drop ram_req_prev and ram_ack_next, pulse ram_reset for 2 cycles (state ABORT), then RESP with rsp_error=1. rsp_rdata is unchanged on error.
- Boundaries:
  - cmd_valid while busy is ignored; cmd_ready=0.
  - Addresses 0 and 2^ADDR_WIDTH-1 are legal; no wrap logic.
  - ram_req_next already high in R_REQ, i.e. before ack is seen: proceed in order. It is consumed in R_DATA.
  - reset_n asserted mid-transaction: everything returns to reset values immediately; ram_reset clears the RAM side.
  - Write strobe never overlaps ram_req_prev.

Decomposition:
- Package ram_hs_pkg:
  - state enum typedef (IDLE, R_SETUP, R_REQ, R_DATA, R_REL, R_DONE, W_SETUP, W_PULSE, W_HOLD, ABORT, RESP).
  - Localparam helper for counter width.
- One sub-module: hs_sync, a parameterized SYNC_STAGES flop chain with async active-low reset to 0, instantiated twice.

Test Plan:
- Read, RAM model with 3-cycle ack and data delays, addr 0x10 holding 0x5A -> four-phase sequence in order; rsp_valid once with rsp_rdata=0x5A, rsp_error=0; all handshake lines 0 afterwards.
- Write 0xA5 to 0xFF -> ram_write high exactly WRITE_PULSE=2 cycles, with address/data stable one cycle before and after; readback of 0xFF returns 0xA5.
- RAM model never asserts ack -> rsp_error=1 at TIMEOUT+sync cycles; ram_reset pulses 2 cycles; next read succeeds.
- Second cmd_valid held during a busy read -> not accepted until after RESP; executed exactly once.
- reset_n pulsed low during R_DATA -> all outputs 0 immediately, ram_reset=1; a fresh read then completes normally.
- Back-to-back alternating write/read at 0x00 and 0xFF over 100 random commands -> scoreboard matches, no strobe overlaps ram_req_prev.
